octal_digit_packer: RTL and testbench
=====================================

// Module: octal_digit_packer
// PURPOSE
//  Inverse of the radix-8 digit slicer. Accepts 11 three-bit octal digits, most-significant
//  first, over a valid/ready stream and packs them into one signed 32-bit word.
//  Digit 0 carries word bits [31:30] only, in its low two bits.
//  Sits at the result end of the radix-8 datapath: digit-serial producer -> this block -> word consumer.
// PARAMETERS
//  WIDTH      32  packed word width
//  DIGIT_W    3   bits per digit (octal)
//  NUM_DIGITS 11  digits per word; must equal ceil(WIDTH/DIGIT_W)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous reset, active-low
//  flush      in   1      synchronous abort of the word being assembled
//  in_valid   in   1      in_digit is valid
//  in_ready   out  1      block accepts a digit this cycle
//  in_digit   in   3      octal digit, MS-first
//  idx        out  4      index (0..10) of the next digit expected
//  out_valid  out  1      out_word holds a completed word
//  out_ready  in   1      consumer takes out_word this cycle
//  out_word   out  32     packed signed word (WIDTH bits)
//  out_ovf    out  1      digit 0 had bit 2 set; the bit was discarded
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, idx=0, acc=0, out_valid=0, out_word=0, out_ovf=0, in_ready=0.
//  A digit is accepted when in_valid & in_ready.
//  States:
//   IDLE    in_ready=1. On accept: acc <= {30'b0, digit}, idx <= 1, go to COLLECT.
//   COLLECT in_ready=1. On accept: acc <= {acc[29:0], digit}, idx <= idx+1.
//           On the accept with idx==10: go to DONE.
//   DONE    in_ready=0, out_valid=1. On out_ready: idx <= 0, go to IDLE.
//  Accumulator is 33 bits (NUM_DIGITS*DIGIT_W):
//   out_word = acc[31:0]
//   out_ovf  = acc[32], which is digit 0 bit 2
//  Both outputs are registered. They become valid in the cycle after the 11th accept,
//  so latency is 1 cycle from the last digit to out_valid.
//  out_word and out_ovf hold stable while out_valid=1 and out_ready=0.
//  They keep their last value after the handshake.
//  No overlap: the first digit of the next word is accepted no earlier than the cycle
//  after the out handshake.
//  in_valid with in_ready=0 (DONE): digit ignored; the producer must hold it.
//  flush=1 in any state: next state IDLE, idx=0, acc=0, out_valid=0.
//   flush overrides a simultaneous digit accept or out handshake.
//   out_word and out_ovf are not cleared.
//  Gaps (in_valid=0) inside COLLECT are allowed for any duration; state and idx hold.
//  idx never exceeds 10. In DONE it reads 10 until the handshake.
//  Reset asserted mid-word discards the partial word immediately (async).
// STRUCTURE
//  Shared package octal_pkg:
//   localparams WIDTH, DIGIT_W, NUM_DIGITS, TOP_BITS=WIDTH-DIGIT_W*(NUM_DIGITS-1)=2
//   state encoding IDLE=2'd0, COLLECT=2'd1, DONE=2'd2
//  The same package is reused by the slicer.
//  One sub-module: octal_digit_counter, a 0..NUM_DIGITS-1 counter with inc/clear/last outputs.
//  The FSM, accumulator and output registers stay in the top module.
// TESTING
//  1 Digits 3,7,7,7,7,7,7,7,7,7,7 back-to-back
//    -> out_word=32'hFFFFFFFF, out_ovf=0, out_valid 1 cycle after the 11th accept.
//  2 Digits 1,0,0,0,0,0,0,0,0,0,0 -> out_word=32'h40000000.
//    Repeat with first digit 5 -> out_word=32'h40000000, out_ovf=1.
//  3 Round trip: 200 random 32-bit words sliced into digits MS-first (2-bit top digit),
//    random in_valid gaps -> out_word equals the original, out_ovf=0.
//  4 Backpressure: out_ready=0 for 5 cycles after completion with in_valid=1
//    -> in_ready=0, out_word stable, no digit consumed.
//    After out_ready=1 the next word starts the following cycle.
//  5 flush after 6 digits -> idx=0, state IDLE.
//    The next 11 digits of 0x12345678 yield out_word=32'h12345678.
//  6 rst_n low during digit 4, then released -> all outputs at reset values asynchronously.
//    A fresh word then packs correctly.

Source files
------------

// File: rtl/octal_digit_packer_pkg.sv
// Shared radix-8 datapath definitions: word/digit geometry and FSM encoding.
// Used by the digit packer here and by the matching digit slicer.
package octal_pkg;

  localparam int WIDTH      = 32;
  localparam int DIGIT_W    = 3;
  localparam int NUM_DIGITS = 11;
  localparam int TOP_BITS   = WIDTH - DIGIT_W * (NUM_DIGITS - 1);
  localparam int ACC_W      = NUM_DIGITS * DIGIT_W;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Append one digit at the LS end; the oldest digit migrates toward the MS end.
  function automatic logic [ACC_W-1:0] shift_in(input logic [ACC_W-1:0] acc,
                                                input logic [DIGIT_W-1:0] digit);
    return {acc[ACC_W-DIGIT_W-1:0], digit};
  endfunction

endpackage

// File: rtl/octal_digit_packer_if.sv
// Digit-in / word-out stream bundle for the octal digit packer, plus the flush strobe.
interface octal_digit_packer_if;
  import octal_pkg::*;

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [DIGIT_W-1:0] in_digit;
  logic [IDX_W-1:0]   idx;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_word;
  logic               out_ovf;

  modport master (
    output flush, in_valid, in_digit, out_ready,
    input  in_ready, idx, out_valid, out_word, out_ovf
  );

  modport slave (
    input  flush, in_valid, in_digit, out_ready,
    output in_ready, idx, out_valid, out_word, out_ovf
  );
endinterface

// File: rtl/octal_digit_packer_counter.sv
// Digit position counter 0..NUM_DIGITS-1; clear wins over inc, and it never wraps past the last index.
module octal_digit_counter
  import octal_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [IDX_W-1:0] count,
  output logic             last
);

  logic [IDX_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != IDX_W'(NUM_DIGITS - 1))) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == IDX_W'(NUM_DIGITS - 1));

endmodule

// File: rtl/octal_digit_packer.sv
// Packs 11 MS-first octal digits into one 32-bit word; digit 0 bit 2 is reported as out_ovf.
module octal_digit_packer
  import octal_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  octal_digit_packer_if.slave   bus
);

  state_t             state_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [WIDTH-1:0]   out_word_reg;
  logic               out_ovf_reg;
  logic               out_valid_reg;
  logic               in_ready_reg;

  logic               accept;
  logic               last;
  logic               cnt_inc;
  logic               cnt_clear;
  logic [ACC_W-1:0]   acc_next;

  assign accept    = bus.in_valid & in_ready_reg;
  assign acc_next  = shift_in(acc_reg, bus.in_digit);
  assign cnt_inc   = accept & ~last;
  assign cnt_clear = bus.flush | ((state_reg == DONE) & bus.out_ready);

  octal_digit_counter u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .clear (cnt_clear),
    .count (bus.idx),
    .last  (last)
  );

  // in_ready/out_valid are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      out_word_reg  <= '0;
      out_ovf_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b0;
    end else if (bus.flush) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          in_ready_reg <= 1'b1;
          if (accept) begin
            acc_reg   <= {{(ACC_W - DIGIT_W){1'b0}}, bus.in_digit};
            state_reg <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            acc_reg <= acc_next;
            if (last) begin
              state_reg     <= DONE;
              out_word_reg  <= acc_next[WIDTH-1:0];
              out_ovf_reg   <= acc_next[ACC_W-1];
              out_valid_reg <= 1'b1;
              in_ready_reg  <= 1'b0;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_word  = out_word_reg;
  assign bus.out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_octal_digit_packer.sv
// Randomized self-checking bench for octal_digit_packer against an arithmetic radix-8 model.
module tb_octal_digit_packer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] last_word;
  logic [2:0]  digs [11];

  octal_digit_packer_if bus ();

  octal_digit_packer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // digit k has weight 8**(10-k); the top digit only contributes two word bits
  function automatic void slice_word(input logic [31:0] w, output logic [2:0] d [11]);
    longint v;
    v = longint'(w);
    for (int k = 10; k >= 0; k--) begin
      d[k] = 3'(v % 8);
      v    = v / 8;
    end
  endfunction

  function automatic logic [32:0] model_pack(input logic [2:0] d [11]);
    longint v;
    v = 0;
    for (int k = 0; k < 11; k++) v = v * 8 + longint'(d[k]);
    return 33'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [2:0] d, input int gap_max);
    int n;
    n = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (n) step();
    bus.in_valid = 1'b1;
    bus.in_digit = d;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL send_timeout in_ready=%0b required 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic recv_word(input string name, input logic [31:0] exp_word,
                           input logic exp_ovf, input int hold_max);
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (!bus.out_valid) begin
      errors++;
      $display("FAIL %s out_valid_timeout got %0b required 1", name, bus.out_valid);
    end
    n = (hold_max > 0) ? int'($urandom_range(hold_max, 0)) : 0;
    repeat (n) step();
    checks++;
    if (bus.out_word !== exp_word || bus.out_ovf !== exp_ovf || bus.idx !== 4'd10 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s word=%h ovf=%0b idx=%0d in_ready=%0b required word=%h ovf=%0b idx=10 in_ready=0",
               name, bus.out_word, bus.out_ovf, bus.idx, bus.in_ready, exp_word, exp_ovf);
    end
    $display("word %s: out_word=%h out_ovf=%0b expected %h/%0b", name, bus.out_word, bus.out_ovf, exp_word, exp_ovf);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.idx !== 4'd0 || bus.out_word !== exp_word) begin
      errors++;
      $display("FAIL %s after_handshake valid=%0b idx=%0d word=%h required 0/0/%h",
               name, bus.out_valid, bus.idx, bus.out_word, exp_word);
    end
    last_word = exp_word;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.idx !== 4'd0 || bus.out_valid !== 1'b0 ||
        bus.out_word !== 32'h0 || bus.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_values rdy=%0b idx=%0d vld=%0b word=%h ovf=%0b required all zero",
               bus.in_ready, bus.idx, bus.out_valid, bus.out_word, bus.out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.idx !== 4'd0) begin
      errors++;
      $display("FAIL reset_release in_ready=%0b idx=%0d required 1/0", bus.in_ready, bus.idx);
    end
    $display("reset: checked");
  endtask

  task automatic test_all_ones();
    digs[0] = 3'd3;
    for (int k = 1; k < 11; k++) digs[k] = 3'd7;
    for (int k = 0; k < 10; k++) send_digit(digs[k], 0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.idx !== 4'd10) begin
      errors++;
      $display("FAIL ones_before_last valid=%0b idx=%0d required 0/10", bus.out_valid, bus.idx);
    end
    send_digit(digs[10], 0);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ones_latency out_valid=%0b required 1", bus.out_valid);
    end
    recv_word("all_ones", 32'hFFFFFFFF, 1'b0, 0);
  endtask

  task automatic test_msb_digit();
    logic [32:0] m;
    for (int k = 0; k < 11; k++) digs[k] = 3'd0;
    digs[0] = 3'd1;
    m = model_pack(digs);
    for (int k = 0; k < 11; k++) send_digit(digs[k], 0);
    recv_word("msb_1", m[31:0], m[32], 0);
    checks++;
    if (last_word !== 32'h40000000) begin
      errors++;
      $display("FAIL msb_1_const word=%h required 40000000", last_word);
    end
    digs[0] = 3'd5;
    m = model_pack(digs);
    for (int k = 0; k < 11; k++) send_digit(digs[k], 1);
    recv_word("msb_5_ovf", 32'h40000000, 1'b1, 2);
    checks++;
    if (m !== {1'b1, 32'h40000000}) begin
      errors++;
      $display("FAIL msb_5_model model=%h required 140000000", m);
    end
  endtask

  task automatic test_round_trip();
    logic [31:0] w;
    for (int t = 0; t < 200; t++) begin
      w = $urandom;
      if (t == 0) w = 32'h0;
      if (t == 1) w = 32'h80000000;
      slice_word(w, digs);
      for (int k = 0; k < 11; k++) send_digit(digs[k], 2);
      recv_word($sformatf("rt%0d", t), w, 1'b0, 2);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w0, w1;
    logic [2:0]  d1 [11];
    w0 = $urandom;
    w1 = $urandom;
    slice_word(w0, digs);
    slice_word(w1, d1);
    for (int k = 0; k < 11; k++) send_digit(digs[k], 0);
    bus.in_valid = 1'b1;
    bus.in_digit = d1[0];
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_word !== w0 || bus.idx !== 4'd10) begin
        errors++;
        $display("FAIL bp_hold%0d rdy=%0b vld=%0b word=%h idx=%0d required 0/1/%h/10",
                 c, bus.in_ready, bus.out_valid, bus.out_word, bus.idx, w0);
      end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.idx !== 4'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release rdy=%0b idx=%0d vld=%0b required 1/0/0", bus.in_ready, bus.idx, bus.out_valid);
    end
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.idx !== 4'd1) begin
      errors++;
      $display("FAIL bp_next_start idx=%0d required 1", bus.idx);
    end
    $display("backpressure: word %h held, next word started", w0);
    for (int k = 1; k < 11; k++) send_digit(d1[k], 1);
    recv_word("bp_next", w1, 1'b0, 0);
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    prev = last_word;
    for (int k = 0; k < 6; k++) send_digit(3'($urandom_range(7, 0)), 1);
    checks++;
    if (bus.idx !== 4'd6) begin
      errors++;
      $display("FAIL flush_pre idx=%0d required 6", bus.idx);
    end
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_digit = 3'd7;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.idx !== 4'd0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_word !== prev) begin
      errors++;
      $display("FAIL flush_state idx=%0d rdy=%0b vld=%0b word=%h required 0/1/0/%h",
               bus.idx, bus.in_ready, bus.out_valid, bus.out_word, prev);
    end
    slice_word(32'h12345678, digs);
    for (int k = 0; k < 11; k++) send_digit(digs[k], 1);
    recv_word("after_flush", 32'h12345678, 1'b0, 1);
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    for (int k = 0; k < 3; k++) send_digit(3'($urandom_range(7, 0)), 0);
    bus.in_valid = 1'b1;
    bus.in_digit = 3'd4;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.idx !== 4'd0 || bus.out_valid !== 1'b0 ||
        bus.out_word !== 32'h0 || bus.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL async_reset rdy=%0b idx=%0d vld=%0b word=%h ovf=%0b required all zero",
               bus.in_ready, bus.idx, bus.out_valid, bus.out_word, bus.out_ovf);
    end
    bus.in_valid = 1'b0;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    w = $urandom;
    slice_word(w, digs);
    for (int k = 0; k < 11; k++) send_digit(digs[k], 1);
    recv_word("after_reset", w, 1'b0, 1);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    last_word     = 32'h0;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_digit  = 3'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_all_ones();
    test_msb_digit();
    test_round_trip();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
